alu_ctl_mdu: RTL and testbench
==============================

Name: alu_ctl_mdu

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes ALUop/func into the 4-bit ALU control code and adds a multi-cycle multiply/divide unit (MDU) with HI/LO registers. The MDU runs MIPS mult/multu/div/divu iteratively and asserts stall to the datapath while it is busy. It sits between the main control unit and the ALU/HI-LO write path of the CPU.

Parameters:
WIDTH, 32, operand width and HI/LO register width (must be ≥ 4)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
valid  in  1  an instruction is being issued this cycle
ALUop  in  2  operation class from main control
func  in  6  R-type function field
a  in  WIDTH  operand rs
b  in  WIDTH  operand rt
ALUCtl  out  4  ALU control code, combinational
busy  out  1  MDU iterating, registered
stall  out  1  hold the pipeline/PC, combinational
done  out  1  one-cycle pulse when HI/LO are updated, registered
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Decode is purely combinational and independent of valid and busy.
  - ALUop 00 -> 2 (add); ALUop 01 -> 6 (sub); ALUop 11 -> 15 (invalid).
  - ALUop 10 by func: 32->2, 34->6, 36->0, 37->1, 39->12, 42->7.
  - ALUop 10 with func 24 mult, 25 multu, 26 div, 27 divu -> 15 (ALU idle).
  - Any other func -> 15.
- start = valid & !busy & ALUop==10 & func in {24,25,26,27}.
- FSM states:
  - IDLE: on start, latch |a|, |b| (signed ops) or a, b (unsigned ops), plus the op and result sign bits; go to RUN with cnt = WIDTH-1.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; cnt decrements; go to FIX when cnt == 0.
  - FIX: apply sign correction, write hi/lo, set done for the next cycle, go to IDLE.
- Latency: start sampled at edge E0. busy = 1 in the cycles after E0 through E(WIDTH+1). HI/LO are written at E(WIDTH+1). done is high for exactly the one cycle after E(WIDTH+1); busy is 0 in that same cycle.
- Multiply result: {hi,lo} = full 2*WIDTH product. For signed, the product sign is sign(a)^sign(b).
- Divide result: lo = quotient, hi = remainder. For signed, the quotient sign is sign(a)^sign(b) and the remainder takes the dividend's sign.
- Divide by zero: same latency; hi = a, lo = all ones.
- Signed MIN / -1: lo = MIN, hi = 0. No trap.
- stall = busy & valid. An issue while busy is not accepted; the datapath re-presents it.
- hi/lo hold their values between operations; only FIX writes them.
- Reset (async, any state including mid-RUN): FSM = IDLE; busy, done, hi, lo, and all internal registers = 0.

Optional Feature:
ALUCTL_DIV_EN
- Defined: func 26/27 start the divide path as specified.
- Undefined: no divider logic is built. func 26/27 decode to ALUCtl 15, never assert start, and leave busy, hi, and lo unchanged. mult/multu are unaffected.

Test Plan:
- Decode sweep (valid = 0): ALUop 0 -> 2; ALUop 1 -> 6; ALUop 2 with func 32/34/36/37/39/42/10 -> 2/6/0/1/12/7/15; ALUop 3 -> 15.
- multu, WIDTH=32, a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE. done pulses exactly 33 cycles after E0; busy is high for 33 cycles.
- mult a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=0 -> hi=7, lo=0xFFFFFFFF. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue a second mult 5 cycles into a busy op -> stall=1 that cycle, no restart, first result unchanged. Assert rst at cycle 10 of a mult -> busy, done, hi, lo read 0 without waiting for a clock edge.
- Build without ALUCTL_DIV_EN: valid, ALUop=2, func=26 -> ALUCtl=15, busy stays 0, hi/lo retain their prior mult result.

Source files
------------

// File: rtl/alu_ctl_mdu.sv
// ALU control decoder plus iterative multiply/divide unit with HI/LO registers.
// Define ALUCTL_DIV_EN to build the divide path (div/divu); otherwise only mult/multu start the MDU.
module alu_ctl_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       ALUCtl,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic             neg_q;
  logic             is_mul, is_md, start, sgn_a, sgn_b;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod;
`ifdef ALUCTL_DIV_EN
  logic             op_div, neg_r, div0;
  logic [WIDTH:0]   div_sh, div_diff;
`endif

  always_comb begin
    ALUCtl = 4'd15;
    case (ALUop)
      2'b00: ALUCtl = 4'd2;
      2'b01: ALUCtl = 4'd6;
      2'b10: begin
        case (func)
          6'd32:   ALUCtl = 4'd2;
          6'd34:   ALUCtl = 4'd6;
          6'd36:   ALUCtl = 4'd0;
          6'd37:   ALUCtl = 4'd1;
          6'd39:   ALUCtl = 4'd12;
          6'd42:   ALUCtl = 4'd7;
          default: ALUCtl = 4'd15;
        endcase
      end
      default: ALUCtl = 4'd15;
    endcase
  end

  assign is_mul = (func == 6'd24) || (func == 6'd25);
`ifdef ALUCTL_DIV_EN
  assign is_md = is_mul || (func == 6'd26) || (func == 6'd27);
`else
  assign is_md = is_mul;
`endif
  assign start = valid && !busy && (ALUop == 2'b10) && is_md;
  assign stall = busy & valid;

  // func[0] clear means the signed variant (mult/div)
  assign sgn_a = ~func[0] & a[WIDTH-1];
  assign sgn_b = ~func[0] & b[WIDTH-1];

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign prod    = {acc_hi, acc_lo};
`ifdef ALUCTL_DIV_EN
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opb};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
`ifdef ALUCTL_DIV_EN
      op_div <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc_hi <= '0;
            acc_lo <= sgn_a ? -a : a;
            opb    <= sgn_b ? -b : b;
            neg_q  <= sgn_a ^ sgn_b;
            cnt    <= CW'(WIDTH - 1);
            busy   <= 1'b1;
            state  <= RUN;
`ifdef ALUCTL_DIV_EN
            op_div <= func[1];
            neg_r  <= sgn_a;
            div0   <= (b == '0);
`endif
          end
        end
        RUN: begin
          // multiplier/dividend shifts out of acc_lo; product/quotient shifts in
`ifdef ALUCTL_DIV_EN
          if (op_div) begin
            acc_hi <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
          end else
`endif
          begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          // divide by zero leaves remainder = |a|, so re-signing it yields a
`ifdef ALUCTL_DIV_EN
          if (op_div) begin
            lo <= div0 ? '1 : (neg_q ? -acc_lo : acc_lo);
            hi <= neg_r ? -acc_hi : acc_hi;
          end else
`endif
          begin
            {hi, lo} <= neg_q ? -prod : prod;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctl_mdu.sv
// Randomized self-checking bench for alu_ctl_mdu against a 64-bit arithmetic reference.
module tb_alu_ctl_mdu;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [1:0]   ALUop = '0;
  logic [5:0]   func = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   ALUCtl;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int checks = 0, errors = 0;

  logic [1:0] dop [10] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
  logic [5:0] dfn [10] = '{6'd0, 6'd0, 6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd10, 6'd0};
  logic [3:0] dex [10] = '{4'd2, 4'd6, 4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7, 4'd15, 4'd15};

  alu_ctl_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ALUop(ALUop), .func(func),
    .a(a), .b(b), .ALUCtl(ALUCtl), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_dec(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd15;
    case (f)
      6'd32: return 4'd2;
      6'd34: return 4'd6;
      6'd36: return 4'd0;
      6'd37: return 4'd1;
      6'd39: return 4'd12;
      6'd42: return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  // {hi, lo} as MIPS defines them, computed in 64-bit arithmetic
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, ux, uy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    q = 0;
    r = 0;
    if (f == 6'd24) return sx * sy;
    if (f == 6'd25) return ux * uy;
    if (y == '0) return {x, 32'hFFFF_FFFF};
    if (f == 6'd26) begin q = sx / sy; r = sx % sy; end
    else begin q = ux / uy; r = ux % uy; end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] e;
    int lat, bc;
    e = ref_md(f, x, y);
    @(negedge clk);
    valid = 1'b1; ALUop = 2'b10; func = f; a = x; b = y;
    #1 chk({tag, ".stall_idle"}, stall, 0);
    @(negedge clk);
    valid = 1'b0; a = $urandom; b = $urandom;
    lat = 1; bc = 0;
    while (!done && lat < 200) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, W + 2);
    chk({tag, ".busy_cycles"}, bc, W + 1);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".hi"}, hi, e[63:32]);
    chk({tag, ".lo"}, lo, e[31:0]);
    @(negedge clk);
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    logic [63:0] e;
    logic [W-1:0] sh, sl;
    logic [5:0] f;
    int n;

    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ALUop = dop[i]; func = dfn[i];
      #1 chk($sformatf("dec.%0d_%0d", dop[i], dfn[i]), ALUCtl, dex[i]);
    end
    for (int i = 24; i < 28; i++) begin
      ALUop = 2'b10; func = 6'(i);
      #1 chk($sformatf("dec.md%0d", i), ALUCtl, 15);
    end
    for (int i = 0; i < 30; i++) begin
      ALUop = 2'($urandom); func = 6'($urandom_range(20, 45));
      #1 chk("dec.rand", ALUCtl, ref_dec(ALUop, func));
    end

    do_op("multu_max", 6'd25, 32'hFFFF_FFFF, 32'd2);
    chk("multu_max.hi_k", hi, 32'h0000_0001);
    chk("multu_max.lo_k", lo, 32'hFFFF_FFFE);
    do_op("mult_neg", 6'd24, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg.hi_k", hi, 32'hFFFF_FFFF);
    chk("mult_neg.lo_k", lo, 32'hFFFF_FFEB);

`ifdef ALUCTL_DIV_EN
    do_op("div_neg", 6'd26, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg.lo_k", lo, 32'hFFFF_FFFD);
    chk("div_neg.hi_k", hi, 32'hFFFF_FFFF);
    do_op("divu_zero", 6'd27, 32'd7, 32'd0);
    chk("divu_zero.hi_k", hi, 32'd7);
    chk("divu_zero.lo_k", lo, 32'hFFFF_FFFF);
    do_op("div_zero_s", 6'd26, 32'hFFFF_FFF9, 32'd0);
    do_op("div_min", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min.lo_k", lo, 32'h8000_0000);
    chk("div_min.hi_k", hi, 32'd0);
`endif

    for (int i = 0; i < 24; i++) begin
`ifdef ALUCTL_DIV_EN
      f = 6'(24 + $urandom_range(0, 3));
`else
      f = 6'(24 + $urandom_range(0, 1));
`endif
      do_op($sformatf("rand%0d_f%0d", i, f), f, pick(), pick());
    end

    // second issue while busy is stalled and ignored
    e = ref_md(6'd24, 32'h0000_1234, 32'hFFFF_0001);
    @(negedge clk);
    valid = 1'b1; ALUop = 2'b10; func = 6'd24; a = 32'h0000_1234; b = 32'hFFFF_0001;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    valid = 1'b1; func = 6'd25; a = 32'd5; b = 32'd9;
    #1 chk("busy_issue.stall", stall, 1);
    @(negedge clk);
    valid = 1'b0;
    #1 chk("busy_idle.stall", stall, 0);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    chk("busy_issue.timeout", n < 200, 1);
    chk("busy_issue.hi", hi, e[63:32]);
    chk("busy_issue.lo", lo, e[31:0]);
    @(negedge clk);
    chk("busy_issue.no_restart", busy, 0);

    // async reset mid-run
    @(negedge clk);
    valid = 1'b1; ALUop = 2'b10; func = 6'd24; a = 32'd123; b = 32'd456;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrst.busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.hi", hi, 0);
    chk("midrst.lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst.stays_idle", busy, 0);

    do_op("post_rst", 6'd24, 32'hFFFF_FFFB, 32'hFFFF_FFF7);

`ifndef ALUCTL_DIV_EN
    sh = hi; sl = lo;
    for (int i = 26; i < 28; i++) begin
      @(negedge clk);
      valid = 1'b1; ALUop = 2'b10; func = 6'(i); a = $urandom; b = $urandom;
      #1 chk($sformatf("nodiv%0d.aluctl", i), ALUCtl, 15);
      @(negedge clk);
      valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("nodiv%0d.busy", i), busy, 0);
        @(negedge clk);
      end
      chk($sformatf("nodiv%0d.done", i), done, 0);
      chk($sformatf("nodiv%0d.hi", i), hi, sh);
      chk($sformatf("nodiv%0d.lo", i), lo, sl);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
